// File: rtl/mvm_sched_pkg.sv
// mvm_sched_pkg: widths, FSM states and job bundle for the mvm scheduler.
// Shared by the scheduler, its interface and the bench.
package mvm_sched_pkg;

  localparam int VEC_ADDRW  = 8;
  localparam int MAT_ADDRW  = 9;
  localparam int OWIDTH     = 32;
  localparam int NUM_OLANES = 8;
  localparam int NOUTW      = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    RUN
  } state_t;

  typedef logic [NUM_OLANES-1:0][OWIDTH-1:0] lanes_t;

  typedef struct packed {
    logic [VEC_ADDRW-1:0] vec_start_addr;
    logic [VEC_ADDRW:0]   vec_num_words;
    logic [MAT_ADDRW-1:0] mat_start_addr;
    logic [MAT_ADDRW:0]   mat_num_rows_per_olane;
    logic [NOUTW-1:0]     num_outputs;
  } job_t;

endpackage

// File: rtl/mvm_sched_if.sv
// mvm_sched_if: command and result valid/ready streams of the scheduler.
// master = job producer / result consumer, slave = mvm_sched.
interface mvm_sched_if;
  import mvm_sched_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [VEC_ADDRW-1:0] cmd_vec_start_addr;
  logic [VEC_ADDRW:0]   cmd_vec_num_words;
  logic [MAT_ADDRW-1:0] cmd_mat_start_addr;
  logic [MAT_ADDRW:0]   cmd_mat_num_rows_per_olane;
  logic [NOUTW-1:0]     cmd_num_outputs;

  logic   res_valid;
  logic   res_ready;
  lanes_t res_data;
  logic   res_last;

  modport master (
    output cmd_valid, cmd_vec_start_addr,
    output cmd_vec_num_words, cmd_mat_start_addr,
    output cmd_mat_num_rows_per_olane, cmd_num_outputs,
    output res_ready,
    input  cmd_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_vec_start_addr,
    input  cmd_vec_num_words, cmd_mat_start_addr,
    input  cmd_mat_num_rows_per_olane, cmd_num_outputs,
    input  res_ready,
    output cmd_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/mvm_sched_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO, power-of-2 DEPTH.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATAW-1:0]         wdata,
  input  logic                     pop,
  output logic [DATAW-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;

  assign count = wptr - rptr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mvm_sched.sv
// mvm_sched: credit-based job issue in front of mvm, result FIFO drain.
// Define MVM_SCHED_PERF_EN to add the perf_* counters.
module mvm_sched
  import mvm_sched_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mvm_sched_if.slave           bus,
  output logic                 mvm_start,
  output logic [VEC_ADDRW-1:0] mvm_vec_start_addr,
  output logic [VEC_ADDRW:0]   mvm_vec_num_words,
  output logic [MAT_ADDRW-1:0] mvm_mat_start_addr,
  output logic [MAT_ADDRW:0]   mvm_mat_num_rows_per_olane,
  input  logic                 mvm_busy,
  input  lanes_t               mvm_result,
  input  logic                 mvm_valid,
  output logic                 idle,
  output logic                 err_overrun
`ifdef MVM_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_jobs,
  output logic [31:0]          perf_busy_cycles,
  output logic [31:0]          perf_credit_stall
`endif
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int CW  = $clog2(RES_DEPTH) + 1;
  localparam int RW  = $bits(lanes_t) + 1;

  state_t           state, state_nx;
  job_t             job, cmd_head, cmd_in;
  logic [CCW-1:0]   cmd_cnt;
  logic             cmd_pop;
  logic [CW-1:0]    res_cnt;
  logic [CW-1:0]    rsv;
  logic [CW-1:0]    free_credit;
  logic             credit_ok;
  logic             reserve;
  logic             beat_wr;
  logic             beat_last;
  logic             run_seen;
  logic [NOUTW-1:0] beat_cnt;
  logic [RW-1:0]    res_head;

  assign cmd_in = {
    bus.cmd_vec_start_addr, bus.cmd_vec_num_words,
    bus.cmd_mat_start_addr, bus.cmd_mat_num_rows_per_olane,
    bus.cmd_num_outputs
  };

  assign bus.cmd_ready = cmd_cnt != CCW'(CMD_DEPTH);

  sync_fifo #(.DATAW($bits(job_t)), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid && bus.cmd_ready),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .count (cmd_cnt)
  );

  // Credit covers both buffered beats and beats promised to a running job.
  assign free_credit = CW'(RES_DEPTH) - res_cnt - rsv;
  assign credit_ok   = 32'(free_credit) >= 32'(job.num_outputs);
  assign beat_last   = beat_cnt + NOUTW'(1) == job.num_outputs;

  always_comb begin
    state_nx = state;
    cmd_pop  = 1'b0;
    reserve  = 1'b0;
    beat_wr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_cnt != '0) begin
          cmd_pop  = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (job.num_outputs == '0) begin
          state_nx = IDLE;
        end else if (credit_ok) begin
          reserve  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = RUN;
      RUN: begin
        beat_wr = mvm_valid && (beat_cnt < job.num_outputs);
        if (run_seen && !mvm_busy &&
            beat_cnt == job.num_outputs)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      job         <= '0;
      beat_cnt    <= '0;
      run_seen    <= 1'b0;
      rsv         <= '0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_pop)
        job <= cmd_head;
      if (state == ISSUE) begin
        beat_cnt <= '0;
        run_seen <= 1'b0;
      end else if (state == RUN) begin
        run_seen <= 1'b1;
        if (beat_wr)
          beat_cnt <= beat_cnt + NOUTW'(1);
      end
      if (reserve)
        rsv <= rsv + CW'(job.num_outputs);
      else if (beat_wr)
        rsv <= rsv - CW'(1);
      if (mvm_valid && !beat_wr)
        err_overrun <= 1'b1;
    end
  end

  sync_fifo #(.DATAW(RW), .DEPTH(RES_DEPTH)) u_res (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_wr),
    .wdata ({beat_last, mvm_result}),
    .pop   (bus.res_valid && bus.res_ready),
    .rdata (res_head),
    .count (res_cnt)
  );

  assign bus.res_valid = res_cnt != '0;
  assign bus.res_data  = bus.res_valid ? res_head[RW-2:0] : '0;
  assign bus.res_last  = bus.res_valid && res_head[RW-1];

  assign mvm_start                  = state == ISSUE;
  assign mvm_vec_start_addr         = job.vec_start_addr;
  assign mvm_vec_num_words          = job.vec_num_words;
  assign mvm_mat_start_addr         = job.mat_start_addr;
  assign mvm_mat_num_rows_per_olane = job.mat_num_rows_per_olane;

  assign idle = state == IDLE && cmd_cnt == '0 && res_cnt == '0;

`ifdef MVM_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_jobs         <= '0;
      perf_busy_cycles  <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (state == RUN && state_nx == IDLE)
        perf_jobs <= perf_jobs + 32'd1;
      if (state == ISSUE || state == RUN)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == CHECK && job.num_outputs != '0 && !credit_ok)
        perf_credit_stall <= perf_credit_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvm_sched.sv
// tb_mvm_sched: random jobs, behavioural mvm model and result scoreboard.
// Expected beats and issue order come from the job list, not the RTL.
`timescale 1ns/1ps
module tb_mvm_sched;
  import mvm_sched_pkg::*;

  localparam int RD = 16;
  localparam int DW = NUM_OLANES * OWIDTH;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mvm_sched_if bus();

  logic                 mvm_start, mvm_busy, mvm_valid;
  logic                 idle, err_overrun;
  logic [VEC_ADDRW-1:0] mvm_vec_start_addr;
  logic [VEC_ADDRW:0]   mvm_vec_num_words;
  logic [MAT_ADDRW-1:0] mvm_mat_start_addr;
  logic [MAT_ADDRW:0]   mvm_mat_num_rows_per_olane;
  lanes_t               mvm_result;
`ifdef MVM_SCHED_PERF_EN
  logic [31:0] perf_jobs, perf_busy_cycles, perf_credit_stall;
`endif

  mvm_sched #(.CMD_DEPTH(4), .RES_DEPTH(RD)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .bus                        (bus),
    .mvm_start                  (mvm_start),
    .mvm_vec_start_addr         (mvm_vec_start_addr),
    .mvm_vec_num_words          (mvm_vec_num_words),
    .mvm_mat_start_addr         (mvm_mat_start_addr),
    .mvm_mat_num_rows_per_olane (mvm_mat_num_rows_per_olane),
    .mvm_busy                   (mvm_busy),
    .mvm_result                 (mvm_result),
    .mvm_valid                  (mvm_valid),
    .idle                       (idle),
    .err_overrun                (err_overrun)
`ifdef MVM_SCHED_PERF_EN
    ,
    .perf_jobs                  (perf_jobs),
    .perf_busy_cycles           (perf_busy_cycles),
    .perf_credit_stall          (perf_credit_stall)
`endif
  );

  job_t  iss_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n_starts = 0;
  int    rr_mode = 1;
  bit    inj = 1'b0;
  bit    m_rst = 1'b0;
  int    m_left = 0;
  int    m_k = 0;
  int    m_gap = 0;
  logic [7:0] m_tag = '0;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lanes(logic [7:0] tag, int k);
    lanes_t v;
    for (int i = 0; i < NUM_OLANES; i++)
      v[i] = {8'h00, tag, 16'(k * 10 + i)};
    return v;
  endfunction

  function automatic job_t mk(int n);
    job_t j;
    j.vec_start_addr         = VEC_ADDRW'($urandom);
    j.vec_num_words          = (VEC_ADDRW+1)'($urandom);
    j.mat_start_addr         = MAT_ADDRW'($urandom);
    j.mat_num_rows_per_olane = (MAT_ADDRW+1)'($urandom);
    j.num_outputs            = NOUTW'(n);
    return j;
  endfunction

  task automatic drive(job_t j);
    bus.cmd_vec_start_addr         = j.vec_start_addr;
    bus.cmd_vec_num_words          = j.vec_num_words;
    bus.cmd_mat_start_addr         = j.mat_start_addr;
    bus.cmd_mat_num_rows_per_olane = j.mat_num_rows_per_olane;
    bus.cmd_num_outputs            = j.num_outputs;
  endtask

  task automatic push(job_t j);
    int t = 0;
    drive(j);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_acc", bus.cmd_ready, 1);
    if (bus.cmd_ready && j.num_outputs != 0)
      iss_q.push_back(j);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (!(idle && exp_q.size() == 0 && iss_q.size() == 0 &&
             m_left == 0 && !mvm_busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("idle", idle, 1);
    chk("drained", exp_q.size() + iss_q.size(), 0);
  endtask

  // mvm model and result scoreboard, all driven/sampled on negedge
  initial begin
    job_t  jj;
    beat_t b;
    forever begin
      @(negedge clk);
      mvm_valid = 1'b0;
      case (rr_mode)
        0:       bus.res_ready = 1'b0;
        1:       bus.res_ready = 1'b1;
        default: bus.res_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("res_extra", exp_q.size(), 1);
        end else begin
          b = exp_q.pop_front();
          chk("res_data", bus.res_data, b.data);
          chk("res_last", bus.res_last, b.last);
        end
      end
      if (!rst || m_rst) begin
        mvm_busy = 1'b0;
        m_left = 0;
        continue;
      end
      if (inj) begin
        mvm_valid  = 1'b1;
        mvm_result = '1;
        inj = 1'b0;
      end else if (mvm_start) begin
        n_starts++;
        if (iss_q.size() == 0) begin
          chk("start_extra", iss_q.size(), 1);
        end else begin
          jj = iss_q.pop_front();
          chk("start_fields",
              {mvm_vec_start_addr, mvm_vec_num_words,
               mvm_mat_start_addr, mvm_mat_num_rows_per_olane},
              {jj.vec_start_addr, jj.vec_num_words,
               jj.mat_start_addr, jj.mat_num_rows_per_olane});
          chk("credit_ok",
              exp_q.size() + int'(jj.num_outputs) <= RD, 1);
          m_left   = int'(jj.num_outputs);
          m_k      = 0;
          m_tag    = jj.vec_start_addr;
          m_gap    = $urandom_range(0, 2);
          mvm_busy = 1'b1;
        end
      end else if (mvm_busy) begin
        if (m_left == 0) begin
          mvm_busy = 1'b0;
        end else if (m_gap > 0) begin
          m_gap--;
        end else begin
          mvm_valid  = 1'b1;
          mvm_result = lanes(m_tag, m_k);
          exp_q.push_back('{last: m_left == 1,
                            data: lanes(m_tag, m_k)});
          m_k++;
          m_left--;
          m_gap = $urandom_range(0, 2);
        end
      end
    end
  end

  initial begin
    job_t j;
    int   lat, s0, nz, t, n;
    bus.cmd_valid = 1'b0;
    drive('0);
    bus.res_ready = 1'b0;
    mvm_valid  = 1'b0;
    mvm_busy   = 1'b0;
    mvm_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_start", mvm_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_idle", idle, 1);
    chk("rst_vec_addr", mvm_vec_start_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    // single job: start three cycles after the push cycle
    j = mk(2);
    drive(j);
    bus.cmd_valid = 1'b1;
    iss_q.push_back(j);
    lat = 0;
    do begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      lat++;
    end while (!mvm_start && lat < 20);
    chk("start_lat", lat, 3);
    wait_idle(200);

    // credit gating: 3 of 4 five-beat jobs fit in 16 entries
    rr_mode = 0;
    s0 = n_starts;
    repeat (4) push(mk(5));
    repeat (150) @(negedge clk);
    chk("credit_issued3", n_starts - s0, 3);
    chk("res_held15", exp_q.size(), 15);
    chk("busy_not_idle", idle, 0);
    rr_mode = 1;
    wait_idle(400);
    chk("credit_issued4", n_starts - s0, 4);

    // zero-output job between two normal ones
    rr_mode = 2;
    s0 = n_starts;
    push(mk(3));
    push(mk(0));
    push(mk(2));
    wait_idle(400);
    chk("zero_skip", n_starts - s0, 2);

    // random job mix with random back-pressure
    s0 = n_starts;
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 7);
      if (n != 0) nz++;
      push(mk(n));
    end
    wait_idle(3000);
    chk("rand_starts", n_starts - s0, nz);

    // command FIFO full while the scheduler waits for credit
    rr_mode = 0;
    s0 = n_starts;
    push(mk(16));
    t = 0;
    while (exp_q.size() < 16 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    push(mk(1));
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) push(mk($urandom_range(1, 3)));
    chk("cmd_full", bus.cmd_ready, 0);
    j = mk(2);
    drive(j);
    bus.cmd_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("cmd_hold", bus.cmd_ready, 0);
    chk("stall_starts", n_starts - s0, 1);
    rr_mode = 1;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd5_acc", bus.cmd_ready, 1);
    if (bus.cmd_ready) iss_q.push_back(j);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_idle(1000);

    // stray mvm_valid while idle
    chk("err_clear", err_overrun, 0);
    inj = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_set", err_overrun, 1);
    chk("ovr_no_beat", bus.res_valid, 0);
    repeat (10) @(negedge clk);
    chk("err_sticky", err_overrun, 1);

    // reset in RUN with one beat buffered
    rr_mode = 0;
    push(mk(4));
    t = 0;
    while (!bus.res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("beat_buf", bus.res_valid, 1);
    chk("mid_run", m_left > 0, 1);
    rst = 1'b0;
    m_rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    iss_q.delete();
    chk("mrst_res_valid", bus.res_valid, 0);
    chk("mrst_res_last", bus.res_last, 0);
    chk("mrst_start", mvm_start, 0);
    chk("mrst_idle", idle, 1);
    chk("mrst_cmd_ready", bus.cmd_ready, 1);
    chk("mrst_err", err_overrun, 0);
    chk("mrst_fields",
        {mvm_vec_start_addr, mvm_vec_num_words,
         mvm_mat_start_addr, mvm_mat_num_rows_per_olane}, 0);
    rst = 1'b1;
    @(negedge clk);
    m_rst = 1'b0;
    @(negedge clk);
    s0 = n_starts;
    push(mk(16));
    t = 0;
    while (n_starts == s0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("full_credit", n_starts - s0, 1);
    rr_mode = 1;
    wait_idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
